alu_pipe: RTL and testbench

- Parametrised, registered successor of the team's combinational 32-bit ALU.
- Adds a valid/ready handshake on input and output, a registered result stage, separate carry and signed-overflow flags, signed compare, shifts, and an iterative multi-cycle multiplier.
- Sits between the operand-issue stage and writeback in the datapath.

---
 rtl/alu_pipe.sv | 202 ++++++++++++++++++++
 tb/tb_alu_pipe.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes on both sides and an iterative
// radix-2 shift-add multiplier; single-cycle ops stream at one per clock.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal,
  output logic [1:0]       dbg_state
);

  localparam int MSB = WIDTH - 1;
  localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_EQ  = 4'h6;
  localparam logic [3:0] OP_LTU = 4'h7;
  localparam logic [3:0] OP_GTU = 4'h8;
  localparam logic [3:0] OP_LTS = 4'h9;
  localparam logic [3:0] OP_SLL = 4'hA;
  localparam logic [3:0] OP_SRL = 4'hB;
  localparam logic [3:0] OP_SRA = 4'hC;
  localparam logic [3:0] OP_MUL = 4'hD;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  // Handshake: a transfer happens on a clock edge where valid && ready are
  // both high. The producer holds its payload steady while valid && !ready;
  // here that means result/flags never change while out_valid && !out_ready.
  logic             out_free;
  logic             accept;
  logic             mul_last;
  logic             out_load;
  logic [WIDTH-1:0] wr_result;
  logic             wr_carry;
  logic             wr_ovf;
  logic             wr_ill;

  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH-1:0] mul_sum;
  logic [CW-1:0]    mul_cnt;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_ill;
  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] sub_res;
  logic [SHW-1:0]   shamt;

  // Single-cycle ALU datapath
  always_comb begin
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_ill  = 1'b0;
    add_full = {1'b0, a} + {1'b0, b};
    sub_res  = a - b;
    shamt    = b[SHW-1:0];
    case (op)
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (a[MSB] == b[MSB]) && (add_full[MSB] != a[MSB]);
      end
      OP_SUB: begin
        alu_res = sub_res;
        alu_c   = (a < b);
        alu_v   = (a[MSB] != b[MSB]) && (sub_res[MSB] != a[MSB]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOT: alu_res = ~a;
      OP_EQ:  alu_res = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_LTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_GTU: alu_res = {{(WIDTH-1){1'b0}}, (a > b)};
      OP_LTS: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL: alu_res = a << shamt;
      OP_SRL: alu_res = a >> shamt;
      OP_SRA: alu_res = $signed(a) >>> shamt;
      OP_MUL: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept && (op == OP_MUL)) state_nx = S_MUL;
      S_MUL:  if (mul_last) state_nx = out_free ? S_IDLE : S_DONE;
      S_DONE: if (out_free) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM: outputs and output-register write selection
  always_comb begin
    out_free  = !out_valid || out_ready;
    in_ready  = (state == S_IDLE) && out_free;
    accept    = in_valid && in_ready;
    mul_last  = (state == S_MUL) && (mul_cnt == CNT_LAST);
    mul_sum   = mul_acc + (mul_b[0] ? mul_a : '0);
    dbg_state = state;
    out_load  = 1'b0;
    wr_result = '0;
    wr_carry  = 1'b0;
    wr_ovf    = 1'b0;
    wr_ill    = 1'b0;
    if ((state == S_IDLE) && accept && (op != OP_MUL)) begin
      out_load  = 1'b1;
      wr_result = alu_res;
      wr_carry  = alu_c;
      wr_ovf    = alu_v;
      wr_ill    = alu_ill;
    end else if (mul_last && out_free) begin
      out_load  = 1'b1;
      wr_result = mul_sum;
    end else if ((state == S_DONE) && out_free) begin
      out_load  = 1'b1;
      wr_result = mul_acc;
    end
  end

  // Multiplier: consumes one bit of b per cycle, LSB first
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a   <= '0;
      mul_b   <= '0;
      mul_acc <= '0;
      mul_cnt <= '0;
    end else if ((state == S_IDLE) && accept && (op == OP_MUL)) begin
      mul_a   <= a;
      mul_b   <= b;
      mul_acc <= '0;
      mul_cnt <= '0;
    end else if (state == S_MUL) begin
      mul_acc <= mul_sum;
      mul_a   <= mul_a << 1;
      mul_b   <= mul_b >> 1;
      mul_cnt <= mul_cnt + 1'b1;
    end
  end

  // Output register; zero is derived from the value being registered
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
    end else if (out_load) begin
      out_valid <= 1'b1;
      result    <= wr_result;
      zero      <= (wr_result == '0);
      carry     <= wr_carry;
      overflow  <= wr_ovf;
      illegal   <= wr_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and randomised bench for alu_pipe with a result scoreboard and
// independent reference model.
module tb_alu_pipe;

  localparam int W   = 32;
  localparam int SHW = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         carry;
  logic         overflow;
  logic         illegal;
  logic [1:0]   dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  bit rand_rdy = 1'b0;

  // {illegal, overflow, carry, zero, result}
  logic [W+3:0] exp_q[$];

  alu_pipe #(.WIDTH(W), .SHW(SHW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry), .overflow(overflow),
    .illegal(illegal), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W+3:0] model(input logic [3:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic [W-1:0] r;
    logic c, v, il;
    r = '0; c = 1'b0; v = 1'b0; il = 1'b0;
    case (o)
      4'h0: begin
        {c, r} = {1'b0, x} + {1'b0, y};
        v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      4'h1: begin
        r = x - y;
        c = (x < y);
        v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
      4'h2: r = x & y;
      4'h3: r = x | y;
      4'h4: r = x ^ y;
      4'h5: r = ~x;
      4'h6: r = {{(W-1){1'b0}}, (x == y)};
      4'h7: r = {{(W-1){1'b0}}, (x < y)};
      4'h8: r = {{(W-1){1'b0}}, (y < x)};
      4'h9: r = {{(W-1){1'b0}}, ($signed(x) < $signed(y))};
      4'hA: r = x << y[SHW-1:0];
      4'hB: r = x >> y[SHW-1:0];
      4'hC: r = $signed(x) >>> y[SHW-1:0];
      4'hD: r = x * y;
      default: il = 1'b1;
    endcase
    return {il, v, c, (r == '0), r};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: call at posedge+1; returns at posedge+1 after the accepting edge
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1; op = o; a = x; b = y;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
    check("accept", 64'(acc), 64'(1));
    if (acc) exp_q.push_back(model(o, x, y));
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 4'($urandom_range(0, 15));
  endtask

  task automatic issue_chk(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [W-1:0] er,
                           input logic ec, input logic ev);
    issue(o, x, y);
    @(negedge clk);
    check(tag, 64'({out_valid, carry, overflow, result}), 64'({1'b1, ec, ev, er}));
    step();
  endtask

  // Scoreboard monitor and output-stability check
  logic         hold_v = 1'b0;
  logic [W+3:0] held;
  logic [W+3:0] e;

  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v)
        check("hold_stable", 64'({out_valid, illegal, overflow, carry, zero, result}),
              64'({1'b1, held}));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'(out_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("result", 64'({illegal, overflow, carry, zero, result}), 64'(e));
        end
      end
      hold_v = out_valid && !out_ready;
      held = {illegal, overflow, carry, zero, result};
    end
  end

  initial begin
    int lat;
    int nv;
    int n;
    bit saw_ready;
    bit v;
    logic [W-1:0] x2, y2;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", 64'({out_valid, illegal, overflow, carry, zero, result}), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'(1));
    step();

    issue(4'h0, 32'hFFFF_FFFF, 32'h1);
    @(negedge clk);
    check("add_wrap", 64'({out_valid, zero, carry, overflow, result}),
          64'({1'b1, 1'b1, 1'b1, 1'b0, 32'h0}));
    step();
    issue_chk("add_ovf", 4'h0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1);
    issue_chk("sub_borrow", 4'h1, 32'h3, 32'h5, 32'hFFFF_FFFE, 1'b1, 1'b0);
    issue_chk("lts", 4'h9, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0);
    issue_chk("ltu", 4'h7, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0);
    issue_chk("sra", 4'hC, 32'h8000_0000, 32'h21, 32'hC000_0000, 1'b0, 1'b0);

    // Back-to-back single-cycle ops at full throughput
    issue(4'h2, 32'hF0F0_1234, 32'h0FF0_FF00);
    issue(4'h5, 32'h0000_FFFF, 32'h0);
    issue(4'hA, 32'h0000_0001, 32'hFFFF_FFFF);
    issue(4'h8, 32'h5, 32'h4);

    // Multiply latency and in_ready blocking
    issue(4'hD, 32'h0001_2345, 32'h0000_1000);
    lat = 0;
    saw_ready = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      v = out_valid;
      if (!v && in_ready) saw_ready = 1'b1;
    end while (!v && lat < 100);
    check("mul_latency", 64'(lat), 64'(33));
    check("mul_in_ready_low", 64'(saw_ready), 64'(0));
    check("mul_result", 64'(result), 64'(32'h1234_5000));
    step();

    // Back-pressure: first result held, second op waits
    out_ready = 1'b0;
    issue(4'h0, 32'h1111_1111, 32'h2222_2222);
    x2 = 32'hAAAA_0000;
    y2 = 32'h0000_5555;
    in_valid = 1'b1; op = 4'h0; a = x2; b = y2;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 64'({out_valid, in_ready, result}), 64'({1'b1, 1'b0, 32'h3333_3333}));
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 64'(in_ready), 64'(1));
    step();
    exp_q.push_back(model(4'h0, x2, y2));
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_second", 64'({out_valid, result}), 64'({1'b1, 32'hAAAA_5555}));
    step();

    // Reset in the middle of a multiply
    issue(4'hD, $urandom, $urandom);
    repeat (9) step();
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mulrst_state", 64'({out_valid, in_ready, dbg_state}), 64'({1'b0, 1'b1, 2'd0}));
    nv = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    check("mulrst_no_output", 64'(nv), 64'(0));
    step();

    // Undefined opcodes
    issue(4'hF, $urandom, $urandom);
    @(negedge clk);
    check("illegal_f", 64'({out_valid, illegal, zero, carry, overflow, result}),
          64'({1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0}));
    step();
    issue(4'hE, 32'h1234_5678, 32'h1);

    // Random ops with random consumer back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      issue(4'($urandom_range(0, 15)), pick(), pick());
      if ($urandom_range(0, 3) == 0) step();
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'(0));
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
